// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default bit period used
// by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers; a push while full is accepted only when
// a pop frees the head slot in the same cycle. The head reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: RX synchronizer, mid-bit sampling FSM and shift register, feeding a
// small byte FIFO. Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int unsigned   CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  uart_rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      rx_meta_q, rx_s_q;
  logic                      push_req_q, push_req_d;
  logic                      frame_req_q, frame_req_d;
  logic                      frame_err_q, overrun_q, overrun_d;
  logic                      fifo_full, fifo_empty;

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  // A pop in the push cycle frees the slot, so only a non-popping full FIFO drops the byte.
  assign overrun_d = push_req_q && fifo_full && !(rx_ready && rx_valid);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push_req_d  = 1'b0;
    frame_req_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_HALF) begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_FULL) begin
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push_req_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_req_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      push_req_q  <= 1'b0;
      frame_req_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      push_req_q  <= push_req_d;
      frame_req_q <= frame_req_d;
      frame_err_q <= frame_req_q;
      overrun_q   <= overrun_d;
    end
  end

  // shift_q is stable until the next frame's first data sample, so it feeds the FIFO directly.
  sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RST),
    .push (push_req_q),
    .wdata(shift_q),
    .full (fifo_full),
    .pop  (rx_ready),
    .rdata(rx_data),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand-written glitch, break,
// overrun, full-with-pop and reset-mid-frame sequences.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int LAT = 156; // RX drive edge to rx_valid edge: 2 sync edges + 1 + 153

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err, overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
  int rise_cyc = -1, ov_cyc = -1, start_cyc = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
    end
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Caller sits #1 after a rising edge; RX is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    RX = 1'b0;
    idle(CPB);
    for (int k = 0; k < 8; k++) begin
      RX = b[k];
      idle(CPB);
    end
    RX = stop;
    idle(CPB);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [7:0] first, input int n);
    logic [7:0] e;
    e = first;
    rx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s valid[%0d]", name, i), 32'(rx_valid), 32'd1);
      check($sformatf("%s data[%0d]", name, i), 32'(rx_data), 32'(e));
      e = e + 8'd1;
      idle(1);
    end
    rx_ready = 1'b0;
    check($sformatf("%s empty", name), 32'(rx_valid), 32'd0);
  endtask

  task automatic frame_and_check(input vec_t v, input string tag);
    int fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(v.data, v.stop);
    RX = 1'b1;
    idle(24);
    check({tag, " frame_err"}, 32'(fe_cnt - fe0), 32'(v.exp_fe));
    check({tag, " overrun"}, 32'(ov_cnt - ov0), 32'd0);
    check({tag, " valid"}, 32'(rx_valid), 32'(v.exp_valid));
    check({tag, " data"}, 32'(rx_data), 32'(v.exp_data));
    if (v.exp_valid) begin
      check({tag, " latency"}, 32'(rise_cyc - start_cyc), 32'(LAT));
      pop_one();
      check({tag, " popped"}, 32'(rx_valid), 32'd0);
    end
  endtask

  initial begin
    int fe0, ov0;
    vec_t v;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};
    vecs[3] = '{data: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_fe: 1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_fe: 0};
    vecs[5] = '{data: 8'h6E, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h6E, exp_fe: 0};

    // Reset state
    idle(3);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    RST = 1'b1;
    idle(4);

    for (int i = 0; i < 6; i++) begin
      rise_cyc = -1;
      frame_and_check(vecs[i], $sformatf("vec%0d", i));
    end

    // Glitch: 5 cycles low is shorter than half a bit
    fe0 = fe_cnt;
    RX = 1'b0;
    idle(5);
    RX = 1'b1;
    idle(30);
    check("glitch valid", 32'(rx_valid), 32'd0);
    check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);
    rise_cyc = -1;
    v = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_fe: 0};
    frame_and_check(v, "after glitch");

    // Break: bad stop followed by a long low line
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(40 * CPB);
    RX = 1'b1;
    idle(30);
    check("break frame_err count", 32'(fe_cnt - fe0), 32'd1);
    check("break valid", 32'(rx_valid), 32'd0);
    rise_cyc = -1;
    v = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_fe: 0};
    frame_and_check(v, "after break");

    // Overrun: five back-to-back frames into a 4-deep FIFO
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    ov_cyc = -1;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(20);
    check("overrun count", 32'(ov_cnt - ov0), 32'd1);
    check("overrun timing", 32'(ov_cyc - start_cyc), 32'(LAT));
    check("overrun frame_err", 32'(fe_cnt - fe0), 32'd0);
    drain_check("overrun drain", 8'h01, 4);

    // Full FIFO with a pop on the fifth byte's push cycle
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    fork
      send_frame(8'h14, 1'b1);
      begin
        idle(LAT - 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(20);
    check("full+pop overrun", 32'(ov_cnt - ov0), 32'd0);
    drain_check("full+pop drain", 8'h11, 4);

    // Reset during DATA with idx = 4, with a byte already queued
    send_frame(8'h5A, 1'b1);
    idle(10);
    check("pre-reset valid", 32'(rx_valid), 32'd1);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(80);
        RST = 1'b0;
        idle(1);
        check("mid reset valid", 32'(rx_valid), 32'd0);
        check("mid reset data", 32'(rx_data), 32'd0);
        RST = 1'b1;
      end
    join
    idle(30);
    check("post reset valid", 32'(rx_valid), 32'd0);
    check("post reset flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    rise_cyc = -1;
    v = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_fe: 0};
    frame_and_check(v, "after reset");

    check("flags never together", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
